core_fetch: RTL

CORE_FETCH -- requirements
Module: core_fetch

---
 rtl/core_uarch_pkg.sv | 34 +++
 rtl/core_prefetch_fifo.sv | 76 +++++++
 rtl/core_fetch.sv | 125 ++++++++++++
 3 files changed

// File: rtl/core_uarch_pkg.sv
// core_uarch_pkg -- shared micro-architecture types for the core front end.
//
// Contents:
//   ptr_t          30-bit word address
//   word_t         32-bit instruction/data word
//   NOP_INSN       instruction presented to decode when nothing is buffered
//   fetch_state_e  fetch FSM states (IDLE / WAIT / DISCARD)
//   ENTRY_W        width of one prefetch buffer entry {insn, pc}
//   PREFETCH_DEPTH buffer depth: 2 when CORE_FETCH_PREFETCH_EN is defined, else 1
package core_uarch_pkg;

  localparam int PTR_W  = 30;
  localparam int WORD_W = 32;

  typedef logic [PTR_W-1:0]  ptr_t;
  typedef logic [WORD_W-1:0] word_t;

  localparam word_t NOP_INSN = 32'hE1A00000;

  typedef enum logic [1:0] {
    FS_IDLE    = 2'd0,  // no request outstanding
    FS_WAIT    = 2'd1,  // request outstanding, response will be kept
    FS_DISCARD = 2'd2   // request outstanding, response will be dropped
  } fetch_state_e;

  localparam int ENTRY_W = WORD_W + PTR_W;

`ifdef CORE_FETCH_PREFETCH_EN
  localparam int PREFETCH_DEPTH = 2;
`else
  localparam int PREFETCH_DEPTH = 1;
`endif

endpackage

// File: rtl/core_prefetch_fifo.sv
// core_prefetch_fifo -- small in-order buffer between the bus and decode.
//
// Entry 0 is always the head; a pop shifts the remaining entries down, so
// the head output is a plain register read with no read-pointer mux.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset (buffer empties)
//   i_push       write i_din at the tail (accepted when not full, or when
//                a pop happens in the same cycle)
//   i_pop        drop the head entry (ignored when empty)
//   i_clear      empty the buffer; overrides push and pop
//   i_din        entry to write
//   o_full       occupancy == DEPTH
//   o_empty      occupancy == 0
//   o_head       head entry (contents undefined when empty)
module core_prefetch_fifo #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 62
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_clear,
  input  logic [WIDTH-1:0] i_din,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_head
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic             w_pop;
  logic             w_push;
  logic [CW-1:0]    w_wr_idx;

  assign o_empty  = (r_count == '0);
  assign o_full   = (r_count == CW'(DEPTH));
  assign w_pop    = i_pop && !o_empty && !i_clear;
  assign w_push   = i_push && (!o_full || w_pop) && !i_clear;
  // The tail slot is computed after the shift caused by a same-cycle pop.
  assign w_wr_idx = w_pop ? (r_count - CW'(1)) : r_count;
  assign o_head   = r_mem[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (w_push && !w_pop) begin
      r_count <= r_count + CW'(1);
    end else if (w_pop && !w_push) begin
      r_count <= r_count - CW'(1);
    end
  end

  // Data storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (w_pop) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        r_mem[i] <= r_mem[i+1];
      end
    end
    if (w_push) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_wr_idx == CW'(i)) begin
          r_mem[i] <= i_din;
        end
      end
    end
  end

endmodule

// File: rtl/core_fetch.sv
// core_fetch -- instruction fetch unit: issues single outstanding word reads,
// buffers returned instructions and presents them to decode.
//
// Build option: CORE_FETCH_PREFETCH_EN defined gives a 2-entry prefetch
// buffer; undefined gives a 1-entry buffer that only refetches once the slot
// is popped (or is being popped in the same cycle).
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   stall             execute cannot take an instruction this cycle
//   branch            redirect request; branch_target is the new word address
//   bus_start         one-cycle read request strobe
//   bus_addr          read word address, held while a request is outstanding
//   bus_ready         one-cycle read completion strobe, bus_data valid with it
//   insn, insn_pc     buffer head (NOP / fetch_pc when empty)
//   insn_valid        buffer non-empty
//   flush             registered copy of branch (high out of reset)
//   o_dbg_state       fetch FSM state
//
// Handshake: bus_start is a single-cycle strobe issued only from IDLE; the
// request stays outstanding (bus_addr stable) until the single-cycle
// bus_ready. Decode consumes the head in every cycle where insn_valid is high
// and stall is low; branch overrides both consumption and bus responses.
module core_fetch
  import core_uarch_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch,
  input  logic [29:0] branch_target,
  output logic        bus_start,
  output logic [29:0] bus_addr,
  input  logic        bus_ready,
  input  logic [31:0] bus_data,
  output logic [31:0] insn,
  output logic [29:0] insn_pc,
  output logic        insn_valid,
  output logic        flush,
  output logic [1:0]  o_dbg_state
);

  fetch_state_e r_state;
  fetch_state_e w_state_nxt;
  ptr_t         r_fetch_pc;
  ptr_t         r_req_addr;
  logic         r_flush;

  logic               w_full;
  logic               w_empty;
  logic [ENTRY_W-1:0] w_head;
  logic               w_pop;
  logic               w_push;
  logic               w_start;

  // Branch wins over consumption and over a same-cycle bus response.
  assign w_pop  = !w_empty && !stall && !branch;
  assign w_push = (r_state == FS_WAIT) && bus_ready && !branch;
  // rst_n gating keeps the strobe low while reset is held, since the FSM
  // sits in IDLE with an empty buffer during reset.
  assign w_start = rst_n && (r_state == FS_IDLE) && !branch && (!w_full || w_pop);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      FS_IDLE: begin
        if (w_start) w_state_nxt = FS_WAIT;
      end
      FS_WAIT: begin
        if (bus_ready)   w_state_nxt = FS_IDLE;
        else if (branch) w_state_nxt = FS_DISCARD;
      end
      FS_DISCARD: begin
        if (bus_ready) w_state_nxt = FS_IDLE;
      end
      default: w_state_nxt = FS_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= FS_IDLE;
      r_fetch_pc <= '0;
      r_req_addr <= '0;
      r_flush    <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_flush <= branch;
      if (branch) begin
        r_fetch_pc <= branch_target;
      end else if (w_start) begin
        r_fetch_pc <= r_fetch_pc + 30'd1;  // wraps 3FFFFFFF -> 0
      end
      if (w_start) begin
        r_req_addr <= r_fetch_pc;
      end
    end
  end

  core_prefetch_fifo #(
    .DEPTH (PREFETCH_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_prefetch_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_clear (branch),
    .i_din   ({bus_data, r_req_addr}),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

  // In IDLE the address being requested is fetch_pc itself; afterwards the
  // captured copy holds bus_addr steady even if a branch moves fetch_pc.
  assign bus_start   = w_start;
  assign bus_addr    = (r_state == FS_IDLE) ? r_fetch_pc : r_req_addr;
  assign insn_valid  = !w_empty;
  assign insn        = w_empty ? NOP_INSN   : w_head[ENTRY_W-1:PTR_W];
  assign insn_pc     = w_empty ? r_fetch_pc : w_head[PTR_W-1:0];
  assign flush       = r_flush;
  assign o_dbg_state = r_state;

endmodule
